// File: rtl/cpu_core_pkg.sv
// Shared encodings for the accumulator-machine sequencer: ISA opcodes, ALU opcodes,
// SKIPCOND condition codes and the instruction-step state enum.
package cpu_core_pkg;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_LOAD     = 4'h1;
    localparam logic [3:0] OP_STORE    = 4'h2;
    localparam logic [3:0] OP_ADD      = 4'h3;
    localparam logic [3:0] OP_SUB      = 4'h4;
    localparam logic [3:0] OP_HALT     = 4'h7;
    localparam logic [3:0] OP_SKIPCOND = 4'h8;
    localparam logic [3:0] OP_JUMP     = 4'h9;
    localparam logic [3:0] OP_CLEAR    = 4'hA;
    localparam logic [3:0] OP_AND      = 4'hB;
    localparam logic [3:0] OP_OR       = 4'hC;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;

    localparam logic [1:0] SKIP_NEG   = 2'b00;
    localparam logic [1:0] SKIP_ZERO  = 2'b01;
    localparam logic [1:0] SKIP_POS   = 2'b10;
    localparam logic [1:0] SKIP_NEVER = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH0,
        S_FETCH1,
        S_FETCH2,
        S_DECODE,
        S_MEM1,
        S_MEM2,
        S_EXEC,
        S_STORE,
        S_HALT
    } state_t;

    function automatic logic [3:0] alu_op_of(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_NOP, OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_HALT,
            OP_SKIPCOND, OP_JUMP, OP_CLEAR, OP_AND, OP_OR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_core_sequencer_skipcond_eval.sv
// SKIPCOND condition check: purely combinational, treats AC as signed.
module skipcond_eval
    import cpu_core_pkg::*;
(
    input  logic [15:0] ac,
    input  logic [1:0]  cond,
    output logic        skip
);

    always_comb begin
        skip = 1'b0;
        case (cond)
            SKIP_NEG:  skip = ac[15];
            SKIP_ZERO: skip = (ac == 16'h0000);
            SKIP_POS:  skip = !ac[15] && (ac != 16'h0000);
            default:   skip = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_core_sequencer.sv
// Multi-cycle fetch/decode/execute core (4/5/7 cycles per instruction); run stalls only at S_FETCH0.
// CPU_CORE_ILLEGAL_TRAP_EN: illegal opcodes trap to S_HALT with illegal_op set; otherwise they act as NOP.
module cpu_core_sequencer
    import cpu_core_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_op1,
    output logic [15:0] alu_op2,
    input  logic [15:0] alu_result,
    output logic [15:0] pc_out,
    output logic [15:0] ac_out,
    output logic [15:0] ir_out,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal_op
);

    state_t      state, state_nxt;
    logic [15:0] pc, mar, mbr, ir, ac;
    logic [3:0]  opcode;
    logic        skip;
    logic        done_q;
    logic        halted_q;

    assign opcode = ir[15:12];

    skipcond_eval u_skip (
        .ac   (ac),
        .cond (ir[11:10]),
        .skip (skip)
    );

    assign mem_addr   = mar;
    assign mem_wdata  = ac;
    assign mem_we     = (state == S_STORE) && !reset;
    assign alu_opcode = alu_op_of(opcode);
    assign alu_op1    = ac;
    assign alu_op2    = mbr;
    assign pc_out     = pc;
    assign ac_out     = ac;
    assign ir_out     = ir;
    assign instr_done = done_q;
    assign halted     = halted_q;

`ifdef CPU_CORE_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= S_FETCH0;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH0: if (run) state_nxt = S_FETCH1;
            S_FETCH1: state_nxt = S_FETCH2;
            S_FETCH2: state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: state_nxt = S_MEM1;
                    OP_STORE:    state_nxt = S_STORE;
                    OP_SKIPCOND: state_nxt = S_EXEC;
                    OP_HALT:     state_nxt = S_HALT;
                    default: begin
`ifdef CPU_CORE_ILLEGAL_TRAP_EN
                        state_nxt = is_legal(opcode) ? S_FETCH0 : S_HALT;
`else
                        state_nxt = S_FETCH0;
`endif
                    end
                endcase
            end
            S_MEM1:  state_nxt = S_MEM2;
            S_MEM2:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_FETCH0;
            S_STORE: state_nxt = S_FETCH0;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= RESET_PC;
            mar      <= 16'h0000;
            mbr      <= 16'h0000;
            ir       <= 16'h0000;
            ac       <= 16'h0000;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
`ifdef CPU_CORE_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_FETCH0: if (run) mar <= pc;
                S_FETCH2: begin
                    mbr <= mem_rdata;
                    ir  <= mem_rdata;
                    pc  <= pc + 16'h0001;
                end
                S_DECODE: begin
                    mar <= {4'b0000, ir[11:0]};
                    // Instructions that need no operand retire straight out of decode.
                    done_q <= (state_nxt == S_FETCH0) || (state_nxt == S_HALT);
                    if (state_nxt == S_HALT) halted_q <= 1'b1;
                    if (opcode == OP_JUMP)  pc <= {4'b0000, ir[11:0]};
                    if (opcode == OP_CLEAR) ac <= 16'h0000;
`ifdef CPU_CORE_ILLEGAL_TRAP_EN
                    if (!is_legal(opcode)) illegal_q <= 1'b1;
`endif
                end
                S_MEM2: mbr <= mem_rdata;
                S_EXEC: begin
                    done_q <= 1'b1;
                    case (opcode)
                        OP_LOAD:                        ac <= mbr;
                        OP_ADD, OP_SUB, OP_AND, OP_OR:  ac <= alu_result;
                        OP_SKIPCOND: if (skip)          pc <= pc + 16'h0001;
                        default: ;
                    endcase
                end
                S_STORE: begin
                    mbr    <= ac;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core_sequencer.sv
// Directed bench for cpu_core_sequencer with a registered-read memory and a behavioural ALU.
module tb_cpu_core_sequencer;

    logic        clock = 1'b0;
    logic        reset, run;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_op1, alu_op2, alu_result;
    logic [15:0] pc_out, ac_out, ir_out;
    logic        instr_done, halted, illegal_op;

    logic [15:0] mem_addr2, mem_wdata2, alu_op1_2, alu_op2_2;
    logic [15:0] pc2, ac2, ir2;
    logic [3:0]  alu_opcode2;
    logic        mem_we2, done2, halted2, illegal2;

    logic [15:0] mem [0:65535];
    logic        ld_en;
    logic [15:0] ld_addr, ld_dat;

    int tests = 0;
    int fails = 0;
    int n;
    logic stall_bad;

    always #5 clock = ~clock;

    cpu_core_sequencer dut (
        .clock(clock), .reset(reset), .run(run),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
        .pc_out(pc_out), .ac_out(ac_out), .ir_out(ir_out),
        .instr_done(instr_done), .halted(halted), .illegal_op(illegal_op)
    );

    // Second core starting at FFFF, fed all-zero memory (every word is a NOP).
    cpu_core_sequencer #(.RESET_PC(16'hFFFF)) dut2 (
        .clock(clock), .reset(reset), .run(run),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_rdata(16'h0000),
        .alu_opcode(alu_opcode2), .alu_op1(alu_op1_2), .alu_op2(alu_op2_2), .alu_result(16'h0000),
        .pc_out(pc2), .ac_out(ac2), .ir_out(ir2),
        .instr_done(done2), .halted(halted2), .illegal_op(illegal2)
    );

    always @(posedge clock) begin
        if (ld_en)       mem[ld_addr]  <= ld_dat;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always_comb begin
        case (alu_opcode)
            4'b0000: alu_result = alu_op1 + alu_op2;
            4'b0001: alu_result = alu_op1 - alu_op2;
            4'b1000: alu_result = alu_op1 & alu_op2;
            4'b1001: alu_result = alu_op1 | alu_op2;
            default: alu_result = 16'h0000;
        endcase
    end

    `define CHK(tag, obs, exp) begin \
        tests++; \
        assert ((obs) === (exp)) else begin \
            fails++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
        end \
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_dat = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Cycles until instr_done is seen; -1 if the budget runs out.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (instr_done) begin
                cycles = i;
                break;
            end
        end
        tests++;
        if (cycles < 0) begin
            fails++;
            $error("FAIL wait_done expired without instr_done");
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; ld_en = 1'b0; ld_addr = 16'h0; ld_dat = 16'h0;
        tick(); tick();

        `CHK("rst_pc", pc_out, 16'h0000)
        `CHK("rst_ac", ac_out, 16'h0000)
        `CHK("rst_ir", ir_out, 16'h0000)
        `CHK("rst_done", instr_done, 1'b0)
        `CHK("rst_halted", halted, 1'b0)
        `CHK("rst_illegal", illegal_op, 1'b0)
        `CHK("rst_we", mem_we, 1'b0)
        `CHK("rst_addr", mem_addr, 16'h0000)
        `CHK("rst_pc2", pc2, 16'hFFFF)

        // Basic program: LOAD 4, ADD 5, STORE 6, HALT
        poke(16'h0, 16'h1004); poke(16'h1, 16'h3005); poke(16'h2, 16'h2006);
        poke(16'h3, 16'h7000); poke(16'h4, 16'h0005); poke(16'h5, 16'h0003);
        poke(16'h6, 16'h0000);
        run = 1'b1; reset = 1'b0;
        wait_done(n);
        `CHK("basic_lat_load", n, 7)
        `CHK("basic_ac_load", ac_out, 16'h0005)
        `CHK("basic_pc_load", pc_out, 16'h0001)
        wait_done(n);
        `CHK("basic_lat_add", n, 7)
        `CHK("basic_ac_add", ac_out, 16'h0008)
        wait_done(n);
        `CHK("basic_lat_store", n, 5)
        `CHK("basic_mem6", mem[6], 16'h0008)
        wait_done(n);
        `CHK("basic_lat_halt", n, 4)
        `CHK("basic_halted", halted, 1'b1)
        `CHK("basic_pc", pc_out, 16'h0004)
        `CHK("basic_ac", ac_out, 16'h0008)
        repeat (6) tick();
        `CHK("halt_sticky", halted, 1'b1)
        `CHK("halt_no_done", instr_done, 1'b0)
        `CHK("halt_pc_hold", pc_out, 16'h0004)

        // SKIPCOND with AC == 0: CLEAR, NOP, 8400 at addr 2 skips addr 3
        reset = 1'b1;
        poke(16'h0, 16'hA000); poke(16'h1, 16'h0000); poke(16'h2, 16'h8400);
        poke(16'h3, 16'h7000); poke(16'h4, 16'h7000);
        reset = 1'b0;
        wait_done(n); wait_done(n); wait_done(n);
        `CHK("skz_lat", n, 5)
        `CHK("skz_pc", pc_out, 16'h0004)

        // SKIPCOND with AC = FFFF: 8000 skips, 8800 and 8C00 do not
        reset = 1'b1;
        poke(16'h0, 16'h1010); poke(16'h1, 16'h8000); poke(16'h2, 16'h7000);
        poke(16'h3, 16'h8800); poke(16'h4, 16'h8C00); poke(16'h5, 16'h7000);
        poke(16'h10, 16'hFFFF);
        reset = 1'b0;
        wait_done(n);
        `CHK("skn_ac", ac_out, 16'hFFFF)
        wait_done(n);
        `CHK("skn_neg_pc", pc_out, 16'h0003)
        wait_done(n);
        `CHK("skn_pos_pc", pc_out, 16'h0004)
        wait_done(n);
        `CHK("skn_never_pc", pc_out, 16'h0005)
        wait_done(n);
        `CHK("skn_halted", halted, 1'b1)

        // JUMP 010, and the FFFF-reset core wrapping to 0000 on a NOP
        reset = 1'b1;
        poke(16'h0, 16'h9010); poke(16'h10, 16'h7000);
        reset = 1'b0;
        wait_done(n);
        `CHK("jmp_lat", n, 4)
        `CHK("jmp_pc", pc_out, 16'h0010)
        `CHK("wrap_done2", done2, 1'b1)
        `CHK("wrap_pc2", pc2, 16'h0000)
        tick();
        `CHK("jmp_fetch_addr", mem_addr, 16'h0010)

        // Stall with run low, then LOAD, then ADD with run dropped mid-flight
        reset = 1'b1; run = 1'b0;
        poke(16'h0, 16'h1011); poke(16'h1, 16'h3011); poke(16'h2, 16'h7000);
        poke(16'h11, 16'h1234);
        reset = 1'b0;
        stall_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_addr !== 16'h0000 || mem_we !== 1'b0 || instr_done !== 1'b0 || pc_out !== 16'h0000)
                stall_bad = 1'b1;
        end
        `CHK("stall_quiet", stall_bad, 1'b0)
        run = 1'b1;
        wait_done(n);
        `CHK("stall_lat", n, 7)
        `CHK("stall_ac", ac_out, 16'h1234)
        tick();
        run = 1'b0;
        wait_done(n);
        `CHK("inflight_lat", n, 6)
        `CHK("inflight_ac", ac_out, 16'h2468)

        // Reset arriving during S_STORE
        reset = 1'b1; run = 1'b1;
        poke(16'h0, 16'h1012); poke(16'h1, 16'h2013);
        poke(16'h12, 16'hABCD); poke(16'h13, 16'h5555);
        reset = 1'b0;
        wait_done(n);
        `CHK("rs_ac", ac_out, 16'hABCD)
        repeat (4) tick();
        `CHK("rs_we_store", mem_we, 1'b1)
        `CHK("rs_addr_store", mem_addr, 16'h0013)
        reset = 1'b1;
        #1;
        `CHK("rs_we_forced", mem_we, 1'b0)
        tick();
        `CHK("rs_mem_kept", mem[16'h13], 16'h5555)
        `CHK("rs_pc", pc_out, 16'h0000)
        `CHK("rs_ac0", ac_out, 16'h0000)
        `CHK("rs_ir", ir_out, 16'h0000)
        `CHK("rs_addr", mem_addr, 16'h0000)
        `CHK("rs_done", instr_done, 1'b0)

        // Illegal opcode F123
        poke(16'h0, 16'hF123); poke(16'h1, 16'h7000);
        reset = 1'b0;
        wait_done(n);
        `CHK("ill_lat", n, 4)
        `CHK("ill_pc", pc_out, 16'h0001)
`ifdef CPU_CORE_ILLEGAL_TRAP_EN
        `CHK("ill_halted", halted, 1'b1)
        `CHK("ill_flag", illegal_op, 1'b1)
        repeat (5) tick();
        `CHK("ill_stays", pc_out, 16'h0001)
`else
        `CHK("ill_halted", halted, 1'b0)
        `CHK("ill_flag", illegal_op, 1'b0)
        wait_done(n);
        `CHK("ill_next_lat", n, 4)
        `CHK("ill_next_halted", halted, 1'b1)
        `CHK("ill_next_pc", pc_out, 16'h0002)
        `CHK("ill_flag_after", illegal_op, 1'b0)
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_core_sequencer.md
# cpu_core_sequencer

- Multi-cycle fetch/decode/execute core for the 16-bit accumulator machine.
- Owns the PC, MAR, MBR, IR and AC registers and the instruction-step state machine.
- Drives the main-memory port upstream and the ALU opcode/operands downstream, writing `alu_result` back into AC.
- Sits between `MainMemory` and `ALU`, replacing the ad-hoc register instances in the top-level computer.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `clock` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `run` in 1: permits leaving S_FETCH0; low pauses at the instruction boundary
- `mem_addr` out 16: `= MAR` (combinational)
- `mem_wdata` out 16: `= AC`
- `mem_we` out 1: high only in S_STORE and only when `reset`=0
- `mem_rdata` in 16: registered memory read data, valid the cycle after the address is presented with `mem_we`=0
- `alu_opcode` out 4: ADD 0000, SUB 0001, AND 1000, OR 1001, decoded from IR
- `alu_op1` out 16: `= AC`
- `alu_op2` out 16: `= MBR`
- `alu_result` in 16: combinational ALU result
- `pc_out`, `ac_out`, `ir_out` out 16: architectural registers
- `instr_done` out 1: one-cycle registered pulse the cycle after an instruction retires
- `halted` out 1: sticky until reset
- `illegal_op` out 1: sticky; only meaningful with the configuration macro

## Operation
- **Instruction format:** `IR[15:12]` = opcode; `IR[11:0]` = operand address, zero-extended to 16 bits.
- **Opcodes:**
  - 0x0 NOP, 0x1 LOAD, 0x2 STORE, 0x3 ADD, 0x4 SUB, 0x7 HALT
  - 0x8 SKIPCOND, 0x9 JUMP, 0xA CLEAR, 0xB AND, 0xC OR
  - All others are illegal.
- **States:**
  - S_FETCH0: `MAR<=PC` when `run`=1, else hold.
  - S_FETCH1: memory read issued.
  - S_FETCH2: `MBR<=mem_rdata`, `IR<=mem_rdata`, `PC<=PC+1`.
  - S_DECODE: `MAR<={4'b0,IR[11:0]}`, then dispatch.
  - S_MEM1: read issued.
  - S_MEM2: `MBR<=mem_rdata`.
  - S_EXEC: LOAD `AC<=MBR`; ADD/SUB/AND/OR `AC<=alu_result`; SKIPCOND evaluated.
  - S_STORE: write `AC` to `mem[MAR]`, `MBR<=AC`.
  - S_HALT: absorbing.
- **Dispatch from S_DECODE:**
  - LOAD/ADD/SUB/AND/OR → S_MEM1.
  - STORE → S_STORE.
  - SKIPCOND → S_EXEC.
  - JUMP: `PC<=IR[11:0]`, → S_FETCH0.
  - CLEAR: `AC<=0`, → S_FETCH0.
  - NOP → S_FETCH0.
  - HALT → S_HALT, `halted<=1`.
  - Illegal: see Configuration.
- **Transitions back to S_FETCH0:** S_MEM1→S_MEM2→S_EXEC→S_FETCH0; S_STORE→S_FETCH0.
- **SKIPCOND** on `IR[11:10]`:
  - 00: skip if AC<0 (signed)
  - 01: skip if AC==0
  - 10: skip if AC>0 (signed)
  - 11: never skip
  - Skip means `PC<=PC+1`.
- **Arithmetic:** all modulo 2^16. PC wraps 16'hFFFF→16'h0000 silently.
- **Reset:**
  - PC=`RESET_PC`; MAR, MBR, IR, AC=0.
  - State S_FETCH0.
  - `instr_done`, `halted`, `illegal_op` = 0.
  - Reset asserted in any state, including S_STORE, wins; `mem_we` is forced low during the reset cycle.
- **Leaving halt:** S_HALT is left only by reset; `run` is ignored there.

## Timing
- Cycles per instruction, `run` held high:
  - NOP/JUMP/CLEAR/HALT: 4
  - STORE, SKIPCOND: 5
  - LOAD/ADD/SUB/AND/OR: 7
- **`instr_done`** is high in the cycle after the retiring state (S_DECODE, S_EXEC or S_STORE). In that cycle `pc_out` and `ac_out` show post-retirement values.
- **HALT** pulses `instr_done` once, coincident with `halted` rising.
- **Stall:** `run` is sampled only in S_FETCH0. A low in any other state has no effect; an instruction in flight always completes.
- **Memory port:** `mem_addr` is stable for the whole of S_FETCH1/S_MEM1/S_STORE. No memory access occurs in S_FETCH0, S_DECODE, S_EXEC or S_HALT.

## Configuration
- **`CPU_CORE_ILLEGAL_TRAP_EN` defined:** an illegal opcode in S_DECODE sets `illegal_op<=1` and `halted<=1`, goes to S_HALT, and pulses `instr_done`.
- **Not defined:** an illegal opcode executes as NOP, and `illegal_op` is tied 0.

## Structure
- **Package `cpu_core_pkg`:**
  - opcode localparams
  - ALU opcode constants
  - state enum (9 states)
  - SKIPCOND condition codes
- **Sub-module `skipcond_eval`:** combinational; inputs `AC` and `IR[11:10]`; output `skip`.
- Everything else stays in one sequencer module.

## Test plan
- **Basic program:** mem[0..3] = 1004, 3005, 2006, 7000; mem[4]=0005, mem[5]=0003; `run`=1 → mem[6]=0008, AC=0008, PC=0004, `halted`=1, four `instr_done` pulses, first pulse 7 cycles after reset release.
- **SKIPCOND:**
  - AC=0000 with 8400 at addr 2 → PC=0004.
  - AC=FFFF with 8000 → skip.
  - AC=FFFF with 8800 → no skip, PC=next.
- **JUMP:** 9010 at addr 0 → PC=0010 at the `instr_done` pulse; next fetch drives `mem_addr`=0010. With `RESET_PC`=FFFF and a NOP at FFFF → PC=0000.
- **Stall:** `run`=0 after reset → state stays S_FETCH0, `mem_addr` constant, `mem_we`=0, no `instr_done` for 20 cycles. Raise `run` → LOAD completes 7 cycles later.
- **Reset mid-STORE:** assert `reset` during S_STORE → `mem_we`=0 that cycle, memory unchanged, all outputs at reset values next cycle.
- **Illegal opcode:** F123 at addr 0.
  - With the macro → `halted`=1, `illegal_op`=1, PC=0001.
  - Without the macro → PC=0001, execution continues, `illegal_op`=0.
